// File: rtl/alt_vipvfr_multibank_controller.sv
// Frame sequencer between the VFR register file and the packet reader: picks a
// descriptor bank, programs and starts the PRC, then waits for and clears its IRQ.
// Optional build macro VFR_AUTO_ADVANCE_EN: frames step through the banks automatically.
module alt_vipvfr_multibank_controller #(
  parameter int NUM_BANKS  = 2,
  parameter int BANK_SEL_W = 1,
  parameter int RES_W      = 16,
  parameter int INTL_W     = 4,
  parameter int ADDR_W     = 32,
  parameter int SAMPLES_W  = 32,
  parameter int WORDS_W    = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic [31:0]                    master_address,
  output logic                           master_write,
  output logic [31:0]                    master_writedata,
  input  logic                           master_waitrequest,
  input  logic                           master_interrupt_recieve,
  input  logic                           go_bit,
  input  logic [BANK_SEL_W-1:0]          next_bank,
  input  logic [NUM_BANKS*RES_W-1:0]     bank_width,
  input  logic [NUM_BANKS*RES_W-1:0]     bank_height,
  input  logic [NUM_BANKS*INTL_W-1:0]    bank_interlaced,
  input  logic [NUM_BANKS*ADDR_W-1:0]    bank_base_address,
  input  logic [NUM_BANKS*SAMPLES_W-1:0] bank_samples,
  input  logic [NUM_BANKS*WORDS_W-1:0]   bank_words,
  output logic [RES_W-1:0]               width_of_next_vid_packet,
  output logic [RES_W-1:0]               height_of_next_vid_packet,
  output logic [INTL_W-1:0]              interlaced_of_next_vid_packet,
  output logic                           do_control_packet,
  output logic                           running,
  output logic                           frame_complete,
  output logic [BANK_SEL_W-1:0]          current_bank,
  output logic [15:0]                    frames_done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LATCH,
    S_WR_ADDR,
    S_WR_SAMPLES,
    S_WR_WORDS,
    S_WR_TYPE,
    S_WR_GO,
    S_WAIT_IRQ,
    S_CLR_IRQ
  } state_t;

  // PRC register map and the two constant values written to it
  localparam logic [31:0] REG_GO      = 32'd0;
  localparam logic [31:0] REG_IRQ     = 32'd2;
  localparam logic [31:0] REG_ADDR    = 32'd3;
  localparam logic [31:0] REG_TYPE    = 32'd4;
  localparam logic [31:0] REG_SAMPLES = 32'd5;
  localparam logic [31:0] REG_WORDS   = 32'd6;
  localparam logic [31:0] GO_IRQ_EN   = 32'd3;
  localparam logic [31:0] IRQ_CLEAR   = 32'd2;

  localparam logic [BANK_SEL_W:0] NUM_BANKS_EXT = (BANK_SEL_W+1)'(NUM_BANKS);

  state_t                  state_q, state_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic [RES_W-1:0]        width_q, width_d;
  logic [RES_W-1:0]        height_q, height_d;
  logic [INTL_W-1:0]       intl_q, intl_d;
  logic                    do_cp_q, do_cp_d;
  logic                    running_q, running_d;
  logic                    complete_q, complete_d;
  logic [BANK_SEL_W-1:0]   bank_q, bank_d;
  logic [15:0]             frames_q, frames_d;
`ifdef VFR_AUTO_ADVANCE_EN
  localparam logic [BANK_SEL_W-1:0] LAST_BANK = BANK_SEL_W'(NUM_BANKS - 1);
  logic                    first_q, first_d;
`endif

  logic                    accepted;
  logic [BANK_SEL_W-1:0]   requested_bank;
  logic [BANK_SEL_W-1:0]   start_bank;
  logic [RES_W-1:0]        sel_width;
  logic [RES_W-1:0]        sel_height;
  logic [INTL_W-1:0]       sel_intl;
  logic [ADDR_W-1:0]       sel_base;
  logic [SAMPLES_W-1:0]    sel_samples;
  logic [WORDS_W-1:0]      sel_words;

  assign accepted = write_q && !master_waitrequest;

  // An out-of-range request falls back to bank 0 rather than reading past the arrays
  assign requested_bank = ({1'b0, next_bank} < NUM_BANKS_EXT) ? next_bank : '0;

`ifdef VFR_AUTO_ADVANCE_EN
  always_comb begin
    if (first_q) begin
      start_bank = requested_bank;
    end else if (bank_q == LAST_BANK) begin
      start_bank = '0;
    end else begin
      start_bank = bank_q + 1'b1;
    end
  end
`else
  assign start_bank = requested_bank;
`endif

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    sel_width   = '0;
    sel_height  = '0;
    sel_intl    = '0;
    sel_base    = '0;
    sel_samples = '0;
    sel_words   = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_q == BANK_SEL_W'(k)) begin
        sel_width   = bank_width[k*RES_W +: RES_W];
        sel_height  = bank_height[k*RES_W +: RES_W];
        sel_intl    = bank_interlaced[k*INTL_W +: INTL_W];
        sel_base    = bank_base_address[k*ADDR_W +: ADDR_W];
        sel_samples = bank_samples[k*SAMPLES_W +: SAMPLES_W];
        sel_words   = bank_words[k*WORDS_W +: WORDS_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    width_d    = width_q;
    height_d   = height_q;
    intl_d     = intl_q;
    do_cp_d    = 1'b0;
    running_d  = running_q;
    complete_d = 1'b0;
    bank_d     = bank_q;
    frames_d   = frames_q;
`ifdef VFR_AUTO_ADVANCE_EN
    first_d    = first_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        write_d = 1'b0;
        if (go_bit) begin
          bank_d    = start_bank;
          running_d = 1'b1;
          state_d   = S_LATCH;
`ifdef VFR_AUTO_ADVANCE_EN
          first_d   = 1'b0;
`endif
        end
      end

      // Next-state values are registered, so each write is set up one state early
      S_LATCH: begin
        width_d  = sel_width;
        height_d = sel_height;
        intl_d   = sel_intl;
        do_cp_d  = 1'b1;
        write_d  = 1'b1;
        addr_d   = REG_ADDR;
        wdata_d  = 32'(sel_base);
        state_d  = S_WR_ADDR;
      end

      S_WR_ADDR: begin
        if (accepted) begin
          addr_d  = REG_SAMPLES;
          wdata_d = 32'(sel_samples);
          state_d = S_WR_SAMPLES;
        end
      end

      S_WR_SAMPLES: begin
        if (accepted) begin
          addr_d  = REG_WORDS;
          wdata_d = 32'(sel_words);
          state_d = S_WR_WORDS;
        end
      end

      S_WR_WORDS: begin
        if (accepted) begin
          addr_d  = REG_TYPE;
          wdata_d = '0;
          state_d = S_WR_TYPE;
        end
      end

      S_WR_TYPE: begin
        if (accepted) begin
          addr_d  = REG_GO;
          wdata_d = GO_IRQ_EN;
          state_d = S_WR_GO;
        end
      end

      S_WR_GO: begin
        if (accepted) begin
          write_d = 1'b0;
          state_d = S_WAIT_IRQ;
        end
      end

      S_WAIT_IRQ: begin
        write_d = 1'b0;
        if (master_interrupt_recieve) begin
          write_d = 1'b1;
          addr_d  = REG_IRQ;
          wdata_d = IRQ_CLEAR;
          state_d = S_CLR_IRQ;
        end
      end

      S_CLR_IRQ: begin
        if (accepted) begin
          write_d    = 1'b0;
          complete_d = 1'b1;
          running_d  = 1'b0;
          frames_d   = frames_q + 16'd1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        write_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      intl_q     <= '0;
      do_cp_q    <= 1'b0;
      running_q  <= 1'b0;
      complete_q <= 1'b0;
      bank_q     <= '0;
      frames_q   <= '0;
`ifdef VFR_AUTO_ADVANCE_EN
      first_q    <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      width_q    <= width_d;
      height_q   <= height_d;
      intl_q     <= intl_d;
      do_cp_q    <= do_cp_d;
      running_q  <= running_d;
      complete_q <= complete_d;
      bank_q     <= bank_d;
      frames_q   <= frames_d;
`ifdef VFR_AUTO_ADVANCE_EN
      first_q    <= first_d;
`endif
    end
  end

  assign master_address                = addr_q;
  assign master_write                  = write_q;
  assign master_writedata              = wdata_q;
  assign width_of_next_vid_packet      = width_q;
  assign height_of_next_vid_packet     = height_q;
  assign interlaced_of_next_vid_packet = intl_q;
  assign do_control_packet             = do_cp_q;
  assign running                       = running_q;
  assign frame_complete                = complete_q;
  assign current_bank                  = bank_q;
  assign frames_done                   = frames_q;

endmodule

// File: tb/tb_alt_vipvfr_multibank_controller.sv
// Scoreboard bench for alt_vipvfr_multibank_controller with three descriptor banks.
// Expected PRC writes are queued when a frame is launched and popped as writes are accepted.
module tb_alt_vipvfr_multibank_controller;

  localparam int NB   = 3;
  localparam int BSW  = 2;
  localparam int RW   = 16;
  localparam int IW   = 4;
  localparam int AW   = 32;
  localparam int SW   = 32;
  localparam int WW   = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic               clock = 1'b0;
  logic               reset;
  logic [31:0]        master_address;
  logic               master_write;
  logic [31:0]        master_writedata;
  logic               master_waitrequest;
  logic               master_interrupt_recieve;
  logic               go_bit;
  logic [BSW-1:0]     next_bank;
  logic [NB*RW-1:0]   bank_width;
  logic [NB*RW-1:0]   bank_height;
  logic [NB*IW-1:0]   bank_interlaced;
  logic [NB*AW-1:0]   bank_base_address;
  logic [NB*SW-1:0]   bank_samples;
  logic [NB*WW-1:0]   bank_words;
  logic [RW-1:0]      width_of_next_vid_packet;
  logic [RW-1:0]      height_of_next_vid_packet;
  logic [IW-1:0]      interlaced_of_next_vid_packet;
  logic               do_control_packet;
  logic               running;
  logic               frame_complete;
  logic [BSW-1:0]     current_bank;
  logic [15:0]        frames_done;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  alt_vipvfr_multibank_controller #(
    .NUM_BANKS(NB), .BANK_SEL_W(BSW), .RES_W(RW), .INTL_W(IW),
    .ADDR_W(AW), .SAMPLES_W(SW), .WORDS_W(WW)
  ) dut (
    .clock                         (clock),
    .reset                         (reset),
    .master_address                (master_address),
    .master_write                  (master_write),
    .master_writedata              (master_writedata),
    .master_waitrequest            (master_waitrequest),
    .master_interrupt_recieve      (master_interrupt_recieve),
    .go_bit                        (go_bit),
    .next_bank                     (next_bank),
    .bank_width                    (bank_width),
    .bank_height                   (bank_height),
    .bank_interlaced               (bank_interlaced),
    .bank_base_address             (bank_base_address),
    .bank_samples                  (bank_samples),
    .bank_words                    (bank_words),
    .width_of_next_vid_packet      (width_of_next_vid_packet),
    .height_of_next_vid_packet     (height_of_next_vid_packet),
    .interlaced_of_next_vid_packet (interlaced_of_next_vid_packet),
    .do_control_packet             (do_control_packet),
    .running                       (running),
    .frame_complete                (frame_complete),
    .current_bank                  (current_bank),
    .frames_done                   (frames_done)
  );

  always #5 clock = ~clock;

  // Distinct descriptor contents per bank so a wrong bank selection is visible
  function automatic logic [RW-1:0] f_width(int k);   return RW'(16'h0140 + k * 16'h0011); endfunction
  function automatic logic [RW-1:0] f_height(int k);  return RW'(16'h00F0 + k * 16'h0022); endfunction
  function automatic logic [IW-1:0] f_intl(int k);    return IW'(4'h5 + k); endfunction
  function automatic logic [31:0]   f_base(int k);    return 32'h8000_0000 + k * 32'h0010_1000; endfunction
  function automatic logic [31:0]   f_samples(int k); return 32'h0001_2C00 + k * 32'h0000_0101; endfunction
  function automatic logic [31:0]   f_words(int k);   return 32'h0000_4B00 + k * 32'h0000_0033; endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_frame(input int k);
    push_wr(32'd3, f_base(k));
    push_wr(32'd5, f_samples(k));
    push_wr(32'd6, f_words(k));
    push_wr(32'd4, 32'd0);
    push_wr(32'd0, 32'd3);
  endtask

  // Accepted writes are compared in order against the scoreboard
  always @(negedge clock) begin
    if (master_write && !master_waitrequest) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {32'd0, master_address}, 64'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", master_address, w.addr);
        check("wr_data", master_writedata, w.data);
      end
    end
  end

  task automatic start_frame(input int exp_bank, input bit keep_go);
    bit seen = 1'b0;
    push_frame(exp_bank);
    go_bit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (running) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("start_timeout", seen, 1'b1);
    check("current_bank", current_bank, exp_bank);
    if (!keep_go) go_bit = 1'b0;
  endtask

  task automatic wait_writes();
    bit seen_hi = 1'b0;
    bit seen_lo = 1'b0;
    for (int i = 0; i < 20 && !seen_hi; i++) begin
      if (master_write) seen_hi = 1'b1;
      else tick();
    end
    for (int i = 0; i < 40 && !seen_lo; i++) begin
      if (!master_write) seen_lo = 1'b1;
      else tick();
    end
    check("writes_timeout", {seen_hi, seen_lo}, 2'b11);
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic finish_frame(input int exp_done);
    bit seen = 1'b0;
    master_interrupt_recieve = 1'b1;
    push_wr(32'd2, 32'd2);
    tick();
    master_interrupt_recieve = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (frame_complete) seen = 1'b1;
      else tick();
    end
    check("complete_timeout", seen, 1'b1);
    check("frames_done", frames_done, exp_done);
    check("running_at_done", running, 1'b0);
    check("clear_consumed", exp_q.size(), 0);
    tick();
    check("complete_one_cycle", frame_complete, 1'b0);
  endtask

  initial begin
    int seq[4];
    reset                    = 1'b1;
    go_bit                   = 1'b0;
    next_bank                = '0;
    master_waitrequest       = 1'b0;
    master_interrupt_recieve = 1'b0;
    for (int k = 0; k < NB; k++) begin
      bank_width[k*RW +: RW]        = f_width(k);
      bank_height[k*RW +: RW]       = f_height(k);
      bank_interlaced[k*IW +: IW]   = f_intl(k);
      bank_base_address[k*AW +: AW] = f_base(k);
      bank_samples[k*SW +: SW]      = f_samples(k);
      bank_words[k*WW +: WW]        = f_words(k);
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_write", master_write, 1'b0);
    check("rst_addr", master_address, 32'd0);
    check("rst_running", running, 1'b0);
    check("rst_frames", frames_done, 16'd0);
    check("rst_bank", current_bank, 2'd0);
    check("rst_width", width_of_next_vid_packet, 16'd0);

    // Frame A: bank 1, no stalls, cycle-exact write sequence
    next_bank = 2'd1;
    start_frame(1, 1'b0);
    check("latch_no_write", master_write, 1'b0);
    tick();
    check("cp_pulse", do_control_packet, 1'b1);
    check("cp_width", width_of_next_vid_packet, f_width(1));
    check("cp_height", height_of_next_vid_packet, f_height(1));
    check("cp_intl", interlaced_of_next_vid_packet, f_intl(1));
    check("first_addr", master_address, 32'd3);
    for (int i = 0; i < 4; i++) begin
      check("wr_consecutive", master_write, 1'b1);
      tick();
      if (i == 0) check("cp_one_cycle", do_control_packet, 1'b0);
    end
    check("wr_last_present", master_write, 1'b1);
    tick();
    check("wait_irq_no_write", master_write, 1'b0);
    check("a_writes_done", exp_q.size(), 0);
    repeat (2) tick();
    check("wait_irq_running", running, 1'b1);
    finish_frame(1);

    // Frame B: bank 2, samples write stalled, early interrupt ignored
    next_bank = 2'd2;
    start_frame(2, 1'b0);
    tick();
    tick();
    check("stall_addr_enter", master_address, 32'd5);
    master_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_write", master_write, 1'b1);
      check("stall_addr", master_address, 32'd5);
      check("stall_data", master_writedata, f_samples(2));
    end
    master_waitrequest = 1'b0;
    tick();
    check("words_addr", master_address, 32'd6);
    master_interrupt_recieve = 1'b1;
    tick();
    master_interrupt_recieve = 1'b0;
    check("type_addr", master_address, 32'd4);
    wait_writes();
    repeat (2) tick();
    check("early_irq_ignored", {running, master_write, frame_complete}, 3'b100);
    finish_frame(2);

    // Frame C: out-of-range bank falls back to bank 0, then reset in WAIT_IRQ
    next_bank = 2'd3;
    start_frame(0, 1'b0);
    wait_writes();
    reset = 1'b1;
    tick();
    check("abort_running", running, 1'b0);
    check("abort_write", master_write, 1'b0);
    check("abort_data", master_writedata, 32'd0);
    check("abort_frames", frames_done, 16'd0);
    check("abort_bank", current_bank, 2'd0);
    check("abort_width", width_of_next_vid_packet, 16'd0);
    reset = 1'b0;
    master_interrupt_recieve = 1'b1;
    tick();
    master_interrupt_recieve = 1'b0;
    repeat (3) tick();
    check("abort_idle", {running, master_write}, 2'b00);

    // Four frames with go held; banks step only in auto-advance builds
`ifdef VFR_AUTO_ADVANCE_EN
    seq = '{2, 0, 1, 2};
`else
    seq = '{2, 2, 2, 2};
`endif
    next_bank = 2'd2;
    for (int f = 0; f < 4; f++) begin
      start_frame(seq[f], f < 3);
      wait_writes();
      finish_frame(f + 1);
    end
    repeat (3) tick();
    check("final_idle", running, 1'b0);
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
